// File: rtl/noc_adder_seq.sv
// rtl/noc_adder_seq.sv - two-phase injection sequencer and result collector for noc_adder_top
// Define NOC_SEQ_CHECKSUM_EN to add the CHECKSUM output (XOR of all captured results).
module noc_adder_seq #(
  parameter int TDATAW      = 32,
  parameter int NUM_PKT     = 10,
  parameter int CNTW        = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
  output logic              START,
  output logic              START2,
  input  logic              DONE_I,
  input  logic [TDATAW-1:0] DATA_I,
  output logic              RES_VALID,
  output logic [TDATAW-1:0] RES_DATA,
  output logic [CNTW-1:0]   RES_IDX,
  output logic              BUSY,
  output logic              FINISHED,
`ifdef NOC_SEQ_CHECKSUM_EN
  output logic [TDATAW-1:0] CHECKSUM,
`endif
  output logic              TIMEOUT_ERR
);

  localparam int WCW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [CNTW-1:0] PKT_TOTAL = CNTW'(NUM_PKT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INJ1,
    S_INJ2,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic              done_q;
  logic              done_rise;
  logic              capture;
  logic [CNTW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic              start_q, start_d;
  logic              start2_q, start2_d;
  logic              res_valid_q, res_valid_d;
  logic [TDATAW-1:0] res_data_q, res_data_d;
  logic [CNTW-1:0]   res_idx_q, res_idx_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              timeout_err_q, timeout_err_d;
`ifdef NOC_SEQ_CHECKSUM_EN
  logic [TDATAW-1:0] checksum_q, checksum_d;
`endif

  // A DONE_I level left over from the previous packet must not count again.
  assign done_rise = DONE_I & ~done_q;

  always_comb begin
    state_d       = state_q;
    pkt_cnt_d     = pkt_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    res_data_d    = res_data_q;
    res_idx_d     = res_idx_q;
    timeout_err_d = timeout_err_q;
    capture       = 1'b0;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (RUN) begin
          pkt_cnt_d     = '0;
          timeout_err_d = 1'b0;
          state_d       = S_INJ1;
        end
      end
      S_INJ1: begin
        state_d = S_INJ2;
      end
      S_INJ2: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          capture    = 1'b1;
          res_data_d = DATA_I;
          res_idx_d  = pkt_cnt_q;
          pkt_cnt_d  = pkt_cnt_q + 1'b1;
          gap_cnt_d  = '0;
          state_d    = S_GAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_FIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = (pkt_cnt_q == PKT_TOTAL) ? S_FIN : S_INJ1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    start_d     = (state_d == S_INJ1);
    start2_d    = (state_d == S_INJ2);
    res_valid_d = capture;
    busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
    finished_d  = (state_d == S_FIN);
  end

`ifdef NOC_SEQ_CHECKSUM_EN
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE || state_q == S_FIN) && RUN) begin
      checksum_d = '0;
    end else if (capture) begin
      checksum_d = checksum_q ^ DATA_I;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      pkt_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      start_q       <= 1'b0;
      start2_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef NOC_SEQ_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      done_q        <= DONE_I;
      pkt_cnt_q     <= pkt_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      start_q       <= start_d;
      start2_q      <= start2_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      timeout_err_q <= timeout_err_d;
`ifdef NOC_SEQ_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign START       = start_q;
  assign START2      = start2_q;
  assign RES_VALID   = res_valid_q;
  assign RES_DATA    = res_data_q;
  assign RES_IDX     = res_idx_q;
  assign BUSY        = busy_q;
  assign FINISHED    = finished_q;
  assign TIMEOUT_ERR = timeout_err_q;
`ifdef NOC_SEQ_CHECKSUM_EN
  assign CHECKSUM    = checksum_q;
`endif

endmodule

// File: tb/tb_noc_adder_seq.sv
// tb/tb_noc_adder_seq.sv - self-checking bench for noc_adder_seq
// Define NOC_SEQ_CHECKSUM_EN to also cover the CHECKSUM output.
module tb_noc_adder_seq;

  localparam int TDATAW      = 32;
  localparam int NUM_PKT     = 3;
  localparam int CNTW        = 8;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 40;

  logic              CLK;
  logic              RST_N;
  logic              RUN;
  logic              START;
  logic              START2;
  logic              DONE_I;
  logic [TDATAW-1:0] DATA_I;
  logic              RES_VALID;
  logic [TDATAW-1:0] RES_DATA;
  logic [CNTW-1:0]   RES_IDX;
  logic              BUSY;
  logic              FINISHED;
  logic              TIMEOUT_ERR;
`ifdef NOC_SEQ_CHECKSUM_EN
  logic [TDATAW-1:0] CHECKSUM;
`endif

  int cyc;
  int n_checks;
  int n_fail;

  noc_adder_seq #(
    .TDATAW      (TDATAW),
    .NUM_PKT     (NUM_PKT),
    .CNTW        (CNTW),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RUN         (RUN),
    .START       (START),
    .START2      (START2),
    .DONE_I      (DONE_I),
    .DATA_I      (DATA_I),
    .RES_VALID   (RES_VALID),
    .RES_DATA    (RES_DATA),
    .RES_IDX     (RES_IDX),
    .BUSY        (BUSY),
    .FINISHED    (FINISHED),
`ifdef NOC_SEQ_CHECKSUM_EN
    .CHECKSUM    (CHECKSUM),
`endif
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; everything after returns sits 1 time unit past the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 64'({START, START2, RES_VALID, BUSY, FINISHED, TIMEOUT_ERR, RES_IDX, RES_DATA}), 64'(0));
`ifdef NOC_SEQ_CHECKSUM_EN
    check_eq({tag, "_csum"}, 64'(CHECKSUM), 64'(0));
`endif
  endtask

  // One run, modelled as event times derived from the latency rules:
  // RUN->START 1, START->START2 1, DONE rise->RES_VALID 1, RES_VALID->next START/FIN GAP_CYC,
  // and FIN TIMEOUT_CYC cycles after WAIT_DONE is entered when DONE never rises.
  task automatic do_run(input bit nominal, input bit spur, input bit stuck, input int abort_pkt);
    int                exp_start, exp_start2, exp_valid, exp_fin, done_at, hold, k;
    logic [TDATAW-1:0] exp_data, val, exp_csum;
    bit                fin_ok, aborted;
    k = 0;
    exp_data = '0;
    exp_csum = '0;
    fin_ok = 1'b0;
    aborted = 1'b0;
    exp_start2 = -1;
    exp_valid = -1;
    exp_fin = -1;
    done_at = -1;
    hold = 1;
    if (stuck) begin
      DONE_I = 1'b1;
      tick();
    end
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    exp_start = cyc;
`ifdef NOC_SEQ_CHECKSUM_EN
    check_eq("csum_run_clear", 64'(CHECKSUM), 64'(0));
`endif
    for (int c = 0; c < 4000; c++) begin
      check_eq("start", 64'(START), 64'(cyc == exp_start));
      check_eq("start2", 64'(START2), 64'(cyc == exp_start2));
      check_eq("res_valid", 64'(RES_VALID), 64'(cyc == exp_valid));
      check_eq("busy", 64'(BUSY), 64'(exp_fin < 0 || cyc < exp_fin));
      check_eq("finished", 64'(FINISHED), 64'(exp_fin >= 0 && cyc >= exp_fin));
      check_eq("timeout_err", 64'(TIMEOUT_ERR), 64'(stuck && exp_fin >= 0 && cyc >= exp_fin));
      if (cyc == exp_valid) begin
        check_eq("res_idx", 64'(RES_IDX), 64'(k - 1));
        check_eq("res_data", 64'(RES_DATA), 64'(exp_data));
`ifdef NOC_SEQ_CHECKSUM_EN
        check_eq("csum_capture", 64'(CHECKSUM), 64'(exp_csum));
`endif
        if (k == NUM_PKT) exp_fin = cyc + GAP_CYC;
        else exp_start = cyc + GAP_CYC;
      end
      if (cyc == exp_fin) begin
        fin_ok = 1'b1;
        if (!stuck) begin
          check_eq("fin_idx", 64'(RES_IDX), 64'(NUM_PKT - 1));
          check_eq("fin_data", 64'(RES_DATA), 64'(exp_data));
        end
`ifdef NOC_SEQ_CHECKSUM_EN
        check_eq("csum_fin", 64'(CHECKSUM), 64'(exp_csum));
        if (nominal) check_eq("csum_nominal", 64'(CHECKSUM), 64'(32'hA3));
`endif
        break;
      end
      if (cyc == exp_start) exp_start2 = cyc + 1;
      if (cyc == exp_start2) begin
        if (k == abort_pkt) begin
          aborted = 1'b1;
          break;
        end
        if (stuck) begin
          exp_fin = cyc + 1 + TIMEOUT_CYC;
        end else begin
          done_at = cyc + (nominal ? 4 : int'($urandom_range(1, 8)));
          hold = (nominal || spur) ? 1 : int'($urandom_range(1, 3));
        end
      end
      val = $urandom;
      if (!stuck && cyc == done_at) begin
        if (nominal) val = TDATAW'(32'hA0 + k);
        exp_data = val;
        exp_csum = exp_csum ^ val;
        exp_valid = cyc + 1;
        k++;
      end
      DATA_I = val;
      DONE_I = stuck
            || (done_at >= 0 && cyc >= done_at && cyc < done_at + hold)
            || (spur && (cyc == exp_start || (exp_valid >= 0 && cyc == exp_valid + 1)));
      tick();
    end
    DONE_I = 1'b0;
    if (abort_pkt < 0) check_eq("run_complete", 64'(fin_ok), 64'(1));
    else check_eq("abort_reached", 64'(aborted), 64'(1));
  endtask

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    RST_N = 1'b0;
    RUN = 1'b0;
    DONE_I = 1'b0;
    DATA_I = '0;

    repeat (5) begin
      tick();
      check_all_zero("reset_outs");
    end
    RST_N = 1'b1;
    repeat (20) begin
      tick();
      check_all_zero("idle_outs");
    end

    do_run(1'b1, 1'b0, 1'b0, -1);
    do_run(1'b0, 1'b0, 1'b1, -1);
    do_run(1'b1, 1'b0, 1'b0, -1);
    do_run(1'b0, 1'b1, 1'b0, -1);
    repeat (3) do_run(1'b0, 1'b0, 1'b0, -1);

    // Reset while packet 1 is waiting for DONE.
    do_run(1'b0, 1'b0, 1'b0, 1);
    tick();
    check_eq("pre_rst_busy", 64'(BUSY), 64'(1));
    RST_N = 1'b0;
    #1;
    check_eq("rst_wait_start", 64'({START, START2}), 64'(0));
    check_eq("rst_wait_busy", 64'(BUSY), 64'(0));
    check_eq("rst_wait_res", 64'({RES_VALID, RES_IDX, RES_DATA}), 64'(0));
    tick();
    RST_N = 1'b1;
    tick();

    // Reset while START is high must drop it without waiting for a clock.
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    check_eq("pre_rst_start", 64'(START), 64'(1));
    RST_N = 1'b0;
    #1;
    check_eq("rst_inj1_start", 64'({START, START2, BUSY}), 64'(0));
    tick();
    RST_N = 1'b1;
    tick();
    check_all_zero("post_rst_idle");

    do_run(1'b0, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_adder_seq.md
Name: noc_adder_seq

Overview:
- Synthesizable injection sequencer that sits directly upstream of noc_adder_top and consumes its completion output.
- Issues NUM_PKT two-phase injections: a START pulse, then a START2 pulse.
- After each injection, waits for DONE, captures DATA_O, reports the result and inserts a gap before the next injection.
- Replaces bench-driven injection so the adder NoC can be exercised on hardware.

Parameters:
- TDATAW, 32, result data width; matches the codebase TDATAW constant.
- NUM_PKT, 10, injections per run, range 1..2^CNTW-1.
- CNTW, 8, width of the packet counter and index.
- GAP_CYC, 2, idle cycles after DONE before the next injection, range 1..255.
- TIMEOUT_CYC, 1024, maximum cycles spent in WAIT_DONE before aborting.

Ports:
- CLK  in  1  single clock, shared with noc_adder_top CLK.
- RST_N  in  1  asynchronous active-low reset.
- RUN  in  1  one-cycle request to start a run; sampled only in IDLE.
- START  out  1  injection phase 1, to noc_adder_top START.
- START2  out  1  injection phase 2, to noc_adder_top START2.
- DONE_I  in  1  from noc_adder_top DONE.
- DATA_I  in  TDATAW  from noc_adder_top DATA_O.
- RES_VALID  out  1  one-cycle pulse when a result is captured.
- RES_DATA  out  TDATAW  captured result; held until the next capture.
- RES_IDX  out  CNTW  0-based packet index of RES_DATA.
- BUSY  out  1  high in every state except IDLE and FIN.
- FINISHED  out  1  high in FIN.
- TIMEOUT_ERR  out  1  sticky; set on timeout.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State is IDLE.
  - All outputs are 0.
  - Counters and done_q are 0.
- All outputs are registered.
- done_q is a 1-cycle delayed copy of DONE_I.
- done_rise = DONE_I & ~done_q.
- IDLE:
  - On RUN=1: pkt_cnt <= 0, TIMEOUT_ERR <= 0, go to INJ1.
- INJ1:
  - START=1 for exactly one cycle, then go to INJ2.
- INJ2:
  - START2=1 for exactly one cycle.
  - START and START2 are never high in the same cycle.
  - wait_cnt <= 0, then go to WAIT_DONE.
- WAIT_DONE:
  - wait_cnt increments each cycle.
  - On done_rise:
    - RES_DATA <= DATA_I (the value sampled in that same cycle).
    - RES_IDX <= pkt_cnt.
    - RES_VALID=1 in the next cycle.
    - pkt_cnt increments.
    - gap_cnt <= 0, then go to GAP.
  - DONE_I held high from a previous packet is not a new completion; only a rising edge counts.
  - If wait_cnt reaches TIMEOUT_CYC-1 with no done_rise: TIMEOUT_ERR <= 1, go to FIN, no capture.
  - If done_rise and timeout occur in the same cycle, done_rise wins.
- GAP:
  - Stays GAP_CYC cycles.
  - Then, if pkt_cnt == NUM_PKT, go to FIN; otherwise go to INJ1.
- FIN:
  - FINISHED=1.
  - On RUN=1: clear FINISHED, TIMEOUT_ERR and pkt_cnt, go to INJ1.
- RUN:
  - Ignored while BUSY.
  - RUN held high in IDLE starts exactly one run per entry into IDLE/FIN.
- DONE_I:
  - Ignored outside WAIT_DONE.
  - done_q still tracks it in every state.
- Latency:
  - RUN to START: 1 cycle.
  - START to START2: 1 cycle.
  - DONE_I rise to RES_VALID: 1 cycle.
  - RES_VALID to the next START: GAP_CYC cycles.
- Reset mid-run:
  - Immediate return to IDLE.
  - START/START2 drop asynchronously.
  - Captured result is lost.
- Counter widths:
  - pkt_cnt is CNTW wide.
  - wait_cnt is $clog2(TIMEOUT_CYC)+1 wide.
  - No wrap is possible within the legal parameter ranges.

Optional Feature:
- Macro: NOC_SEQ_CHECKSUM_EN.
- When defined:
  - Adds output CHECKSUM (TDATAW bits).
  - CHECKSUM is cleared to 0 on reset and on each run start.
  - On every capture: CHECKSUM <= CHECKSUM ^ DATA_I.
  - The updated value is visible in the same cycle as RES_VALID.
  - The value is held in FIN.
- When undefined: no CHECKSUM port and no accumulator logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle:
  - RST_N=0 for 5 cycles, then 1, with RUN=0 for 20 cycles.
  - Required: all outputs stay 0; START/START2 never pulse.
- Nominal run:
  - NUM_PKT=3, RUN pulse; bench model raises DONE_I 4 cycles after START2 with DATA_I=0xA0+idx, then lowers DONE_I.
  - Required: START/START2 pulse pairs are exactly 1 cycle apart.
  - Required: RES_VALID fires 3 times with RES_IDX 0,1,2 and RES_DATA 0xA0,0xA1,0xA2.
  - Required: the next START comes 2 cycles after each RES_VALID.
  - Required: FINISHED=1 after the third GAP.
- Stuck DONE:
  - DONE_I tied high from before RUN.
  - Required: no capture, because there is no rising edge.
  - Required: TIMEOUT_ERR=1 and FINISHED=1 exactly TIMEOUT_CYC cycles after entering WAIT_DONE.
- Spurious DONE:
  - DONE_I pulses during INJ1 and during GAP.
  - Required: ignored, RES_VALID stays 0.
  - Required: a later valid rise in WAIT_DONE captures normally.
- Reset mid-run:
  - Assert RST_N=0 while in WAIT_DONE of packet 1.
  - Required: START, START2, BUSY and RES_* are 0 immediately.
  - Required: a RUN after release restarts from RES_IDX 0.
- Checksum build (NOC_SEQ_CHECKSUM_EN defined):
  - Same stimulus as the nominal run.
  - Required: CHECKSUM = 0xA0^0xA1^0xA2 = 0xA3 in FIN.
  - Required: a rerun restarts CHECKSUM from 0.
